polynomial_decoder: RTL and testbench

POLYNOMIAL_DECODER -- requirements
Module: polynomial_decoder

---
 rtl/polynomial_decoder.sv | 153 +++++++++++++++
 tb/tb_polynomial_decoder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/polynomial_decoder.sv
// polynomial_decoder
//   Unpacks 14-bit polynomial coefficients from a byte RAM (7 bytes carry
//   4 coefficients) and writes them, optionally reduced mod Q, into a
//   16-bit-wide poly RAM. One run decodes NCOEF coefficients, one group of
//   four at a time: 8 LOAD cycles fetch the group bytes, 4 WRITE cycles
//   store the four coefficients, then a single FIN cycle pulses done.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : one-cycle pulse, begins a run (ignored unless idle)
//   done     : one-cycle pulse, run complete
//   IR_addr  : byte RAM read address (data returns one cycle later)
//   IR_do    : byte RAM read data
//   PR_we    : poly RAM write enable
//   PR_addr  : poly RAM coefficient address
//   PR_di    : poly RAM write data, bits 15:14 always 0
//
// All outputs are registers fed from the next-state logic, so nothing on
// IR_do or start reaches an output in the same cycle.
module polynomial_decoder #(
   parameter int NCOEF  = 512,
   parameter int Q      = 12289,
   parameter int REDUCE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        done,
   output logic [9:0]  IR_addr,
   input  logic [7:0]  IR_do,
   output logic        PR_we,
   output logic [8:0]  PR_addr,
   output logic [15:0] PR_di
);

   localparam int NGRP = NCOEF / 4;
   localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [GW-1:0] LAST_G = GW'(NGRP - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, FIN} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] grp_idx, grp_idx_nxt;
   logic [2:0]    cnt, cnt_nxt;
   logic [55:0]   grp_reg, grp_reg_nxt;
   logic          done_nxt, we_nxt;
   logic [9:0]    ir_addr_nxt;
   logic [8:0]    pr_addr_nxt;
   logic [15:0]   pr_di_nxt;

   function automatic logic [9:0] byte_addr(input logic [GW-1:0] g, input logic [2:0] k);
      return 10'((int'(g) * 7) + int'(k));
   endfunction

   // At most one subtraction is needed: the largest 14-bit value is below 2Q.
   function automatic logic [13:0] reduce_coef(input logic [13:0] v);
      if (REDUCE != 0 && int'(v) >= Q) return 14'(int'(v) - Q);
      return v;
   endfunction

   // With b0 in bits 7:0 the packing is a plain little-endian bit stream,
   // so coefficient j is simply bits 14j+13 .. 14j of the group register.
   function automatic logic [15:0] coef_word(input logic [55:0] grp, input logic [1:0] j);
      return {2'b00, reduce_coef(grp[14*int'(j) +: 14])};
   endfunction

   function automatic logic [8:0] coef_addr(input logic [GW-1:0] g, input logic [1:0] j);
      return 9'({g, j});
   endfunction

   always_comb begin
      state_nxt   = state;
      grp_idx_nxt = grp_idx;
      cnt_nxt     = cnt;
      grp_reg_nxt = grp_reg;
      done_nxt    = 1'b0;
      we_nxt      = 1'b0;
      ir_addr_nxt = '0;
      pr_addr_nxt = '0;
      pr_di_nxt   = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = LOAD;
               grp_idx_nxt = '0;
               cnt_nxt     = '0;
               ir_addr_nxt = byte_addr('0, 3'd0);
            end
         end
         LOAD: begin
            // Byte k-1 arrives during LOAD cycle k (one-cycle RAM latency).
            if (cnt != 3'd0) grp_reg_nxt[8*(int'(cnt)-1) +: 8] = IR_do;
            if (cnt < 3'd6) ir_addr_nxt = byte_addr(grp_idx, cnt + 3'd1);
            if (cnt == 3'd7) begin
               // b6 is still landing this cycle, but c0 only uses b0/b1,
               // which are already in the register.
               state_nxt   = WRITE;
               cnt_nxt     = '0;
               we_nxt      = 1'b1;
               pr_addr_nxt = coef_addr(grp_idx, 2'd0);
               pr_di_nxt   = coef_word(grp_reg, 2'd0);
            end else begin
               cnt_nxt = cnt + 3'd1;
            end
         end
         WRITE: begin
            if (cnt != 3'd3) begin
               cnt_nxt     = cnt + 3'd1;
               we_nxt      = 1'b1;
               pr_addr_nxt = coef_addr(grp_idx, cnt[1:0] + 2'd1);
               pr_di_nxt   = coef_word(grp_reg, cnt[1:0] + 2'd1);
            end else if (grp_idx != LAST_G) begin
               state_nxt   = LOAD;
               grp_idx_nxt = grp_idx + GW'(1);
               cnt_nxt     = '0;
               ir_addr_nxt = byte_addr(grp_idx + GW'(1), 3'd0);
            end else begin
               state_nxt = FIN;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         grp_idx <= '0;
         cnt     <= '0;
         grp_reg <= '0;
         done    <= 1'b0;
         PR_we   <= 1'b0;
         IR_addr <= '0;
         PR_addr <= '0;
         PR_di   <= '0;
      end else begin
         state   <= state_nxt;
         grp_idx <= grp_idx_nxt;
         cnt     <= cnt_nxt;
         grp_reg <= grp_reg_nxt;
         done    <= done_nxt;
         PR_we   <= we_nxt;
         IR_addr <= ir_addr_nxt;
         PR_addr <= pr_addr_nxt;
         PR_di   <= pr_di_nxt;
      end
   end

endmodule

// File: tb/tb_polynomial_decoder.sv
// Testbench for polynomial_decoder: a 512-coefficient REDUCE=1 instance and
// an 8-coefficient REDUCE=0 instance share one byte RAM model. Expected
// writes are queued when a run is launched; negedge monitors pop and compare.
module tb_polynomial_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, start2 = 1'b0;
   logic        done, done2;
   logic [9:0]  ir_addr, ir_addr2;
   logic [7:0]  ir_do, ir_do2;
   logic        pr_we, pr_we2;
   logic [8:0]  pr_addr, pr_addr2;
   logic [15:0] pr_di, pr_di2;

   always #5 clk = ~clk;

   polynomial_decoder dut (
      .clk(clk), .rst(rst), .start(start), .done(done),
      .IR_addr(ir_addr), .IR_do(ir_do),
      .PR_we(pr_we), .PR_addr(pr_addr), .PR_di(pr_di)
   );

   polynomial_decoder #(.NCOEF(8), .REDUCE(0)) dut_small (
      .clk(clk), .rst(rst), .start(start2), .done(done2),
      .IR_addr(ir_addr2), .IR_do(ir_do2),
      .PR_we(pr_we2), .PR_addr(pr_addr2), .PR_di(pr_di2)
   );

   logic [7:0] mem [0:1023];
   always @(posedge clk) begin
      ir_do  <= mem[ir_addr];
      ir_do2 <= mem[ir_addr2];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;
   int exp_q[$], exp2_q[$];
   int exp_done = -1, exp_done2 = -1;
   bit done_seen = 1'b0, done_seen2 = 1'b0;
   int coefs [0:511];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Monitors: each write is packed as {addr, data} = addr<<16 | data.
   always @(negedge clk) begin
      if (rst) begin
         if (pr_we) begin
            if (exp_q.size() == 0) chk("unexpected write", int'({pr_addr, pr_di}), -1);
            else chk("write addr/data", int'({pr_addr, pr_di}), exp_q.pop_front());
         end
         if (done) begin
            chk("done cycle", cyc, exp_done);
            chk("done with we", int'(pr_we), 0);
            exp_done  = -1;
            done_seen = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (pr_we2) begin
            if (exp2_q.size() == 0) chk("small unexpected write", int'({pr_addr2, pr_di2}), -1);
            else chk("small write addr/data", int'({pr_addr2, pr_di2}), exp2_q.pop_front());
         end
         if (done2) begin
            chk("small done cycle", cyc, exp_done2);
            exp_done2  = -1;
            done_seen2 = 1'b1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 1024; i++) mem[i] = v;
   endtask

   task automatic push_const(input bit which, input int n, input int val);
      for (int i = 0; i < n; i++)
         if (which) exp2_q.push_back((i << 16) | val);
         else       exp_q.push_back((i << 16) | val);
   endtask

   // Inverse of the packing: b0=c0[7:0], b1={c1[1:0],c0[13:8]}, ...
   task automatic put_group(input int g, input logic [13:0] c0, input logic [13:0] c1,
                            input logic [13:0] c2, input logic [13:0] c3);
      mem[7*g+0] = c0[7:0];
      mem[7*g+1] = {c1[1:0], c0[13:8]};
      mem[7*g+2] = c1[9:2];
      mem[7*g+3] = {c2[3:0], c1[13:10]};
      mem[7*g+4] = c2[11:4];
      mem[7*g+5] = {c3[5:0], c2[13:12]};
      mem[7*g+6] = c3[13:6];
   endtask

   // Called at posedge+1; start is sampled at the next edge.
   task automatic go(input bit which, input int groups);
      if (which) begin
         start2 = 1'b1; exp_done2 = cyc + 12*groups + 1; done_seen2 = 1'b0;
      end else begin
         start = 1'b1; exp_done = cyc + 12*groups + 1; done_seen = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0;
   endtask

   task automatic wait_done(input bit which, input string nm);
      int n = 0;
      while (!(which ? done_seen2 : done_seen) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      chk({nm, " done seen"}, int'(which ? done_seen2 : done_seen), 1);
      chk({nm, " writes drained"}, which ? exp2_q.size() : exp_q.size(), 0);
      if (which) begin exp2_q.delete(); exp_done2 = -1; end
      else       begin exp_q.delete();  exp_done  = -1; end
   endtask

   task automatic push_coefs();
      for (int i = 0; i < 512; i++) exp_q.push_back((i << 16) | coefs[i]);
   endtask

   initial begin
      int t0, n;
      fill(8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("reset done", int'(done), 0);
      chk("reset PR_we", int'(pr_we), 0);
      chk("reset IR_addr", int'(ir_addr), 0);
      chk("reset PR_addr", int'(pr_addr), 0);
      chk("reset PR_di", int'(pr_di), 0);
      chk("reset small PR_we/done", int'({pr_we2, done2}), 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle after reset", int'({pr_we, done, ir_addr}), 0);

      // All-zero bytes: 512 zero writes, done 1537 cycles after start.
      fill(8'h00);
      push_const(0, 512, 0);
      go(0, 128);
      wait_done(0, "zeros");

      // All 0xFF: 16383 reduces to 4094; unreduced instance keeps 0x3FFF.
      fill(8'hFF);
      push_const(0, 512, 4094);
      go(0, 128);
      wait_done(0, "ones reduced");
      push_const(1, 8, 16'h3FFF);
      go(1, 2);
      wait_done(1, "ones unreduced");

      // Group 0 = 01 C0 00 00 00 00 00 -> c0=1, c1=3.
      fill(8'h00);
      mem[0] = 8'h01; mem[1] = 8'hC0;
      exp_q.push_back((0 << 16) | 1);
      exp_q.push_back((1 << 16) | 3);
      for (int i = 2; i < 512; i++) exp_q.push_back(i << 16);
      go(0, 128);
      wait_done(0, "01 C0 vector");

      // Back-to-back start right after done: group 0 b6=FF -> c3=0x3FC0,
      // reduced to 16320-12289=4031 on the REDUCE=1 instance.
      fill(8'h00);
      mem[6] = 8'hFF;
      for (int i = 0; i < 512; i++) exp_q.push_back((i << 16) | ((i == 3) ? 4031 : 0));
      go(0, 128);
      wait_done(0, "b6=FF reduced");
      for (int i = 0; i < 8; i++) exp2_q.push_back((i << 16) | ((i == 3) ? 16'h3FC0 : 0));
      go(1, 2);
      wait_done(1, "b6=FF unreduced");

      // Round trip with random in-range coefficients, plus a stray start
      // pulse during group 5 LOAD that must change nothing.
      fill(8'h00);
      for (int i = 0; i < 512; i++) coefs[i] = $urandom_range(12288, 0);
      coefs[0] = 12288; coefs[1] = 0;
      for (int g = 0; g < 128; g++)
         put_group(g, 14'(coefs[4*g]), 14'(coefs[4*g+1]), 14'(coefs[4*g+2]), 14'(coefs[4*g+3]));
      push_coefs();
      go(0, 128);
      t0 = exp_done - 12*128 - 1;
      while (cyc < t0 + 63) begin @(posedge clk); #1; end
      chk("IR_addr in group 5 load", int'(ir_addr), 37);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(0, "round trip");

      // Reset in the middle of group 40's WRITE, then a clean full rerun.
      push_coefs();
      go(0, 128);
      n = 0;
      while (!(pr_we && pr_addr == 9'd161) && n < 2000) begin @(posedge clk); #1; n++; end
      chk("reached group 40 write", int'(pr_we && pr_addr == 9'd161), 1);
      #2 rst = 1'b0;
      #1;
      chk("PR_we drops on reset", int'(pr_we), 0);
      chk("no done on reset", int'(done), 0);
      exp_q.delete();
      exp_done = -1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("idle after abort", int'({pr_we, done, ir_addr, pr_addr}), 0);
      chk("no done after abort", int'(done_seen), 0);
      push_coefs();
      go(0, 128);
      wait_done(0, "rerun after reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
